// File: rtl/uart_rx_fifo_if.sv
// Bundle of receive-FIFO data, control and status signals between the
// UART receive path (slave side = FIFO) and the register slave / bench (master).
interface uart_rx_fifo_if #(
    parameter int DATA_UART  = 8,
    parameter int DEPTH_LOG2 = 4
) ();

    logic                  en_i;
    logic                  clr_i;
    logic [DATA_UART-1:0]  rx_data_i;
    logic                  rx_valid_i;
    logic                  rd_en_i;
    logic [DATA_UART-1:0]  rd_data_o;
    logic                  empty_o;
    logic                  full_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic [DEPTH_LOG2:0]   thresh_i;
    logic                  irq_o;
    logic                  overrun_o;
    logic                  ovr_clr_i;

    modport master (
        output en_i, clr_i, rx_data_i, rx_valid_i, rd_en_i, thresh_i, ovr_clr_i,
        input  rd_data_o, empty_o, full_o, level_o, irq_o, overrun_o
    );

    modport slave (
        input  en_i, clr_i, rx_data_i, rx_valid_i, rd_en_i, thresh_i, ovr_clr_i,
        output rd_data_o, empty_o, full_o, level_o, irq_o, overrun_o
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with
// registered occupancy/full/empty flags, sticky overrun and level interrupt.
module uart_rx_fifo #(
    parameter int DATA_UART  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    uart_rx_fifo_if.slave    bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_UART-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wp_q, wp_d;
    logic [PTR_W-1:0]     rp_q, rp_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 irq_q, irq_d;
    logic                 overrun_q, overrun_d;

    logic                 push_req;
    logic                 pop_req;
    logic                 push_acc;
    logic                 drop;
    logic                 mem_we;

    // A push into a full FIFO is still accepted when the same cycle's pop
    // frees the head slot, since wp equals rp in that state.
    always_comb begin
        push_req = bus.rx_valid_i & bus.en_i;
        pop_req  = bus.rd_en_i & ~empty_q;
        push_acc = push_req & (~full_q | pop_req);
        drop     = push_req & full_q & ~pop_req & ~bus.clr_i;
        mem_we   = push_acc & ~bus.clr_i & rstn_i;
    end

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        if (bus.clr_i) begin
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
        end else begin
            if (push_acc) begin
                wp_d = wp_q + PTR_W'(1);
            end
            if (pop_req) begin
                rp_d = rp_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push_acc) - LVL_W'(pop_req);
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr_i) begin
            overrun_d = 1'b0;
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == FULL_LEVEL);
        irq_d   = (level_d >= bus.thresh_i) && (bus.thresh_i != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wp_q      <= '0;
            rp_q      <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wp_q] <= bus.rx_data_i;
        end
    end

    assign bus.rd_data_o = mem_q[rp_q];
    assign bus.empty_o   = empty_q;
    assign bus.full_o    = full_q;
    assign bus.level_o   = level_q;
    assign bus.irq_o     = irq_q;
    assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard-driven bench for uart_rx_fifo: a queue models stored characters,
// each scenario task drives traffic and compares DUT outputs against the model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int LW    = DL2 + 1;

    logic clk;
    logic rstn;

    uart_rx_fifo_if #(.DATA_UART(DW), .DEPTH_LOG2(DL2)) bus ();

    uart_rx_fifo #(.DATA_UART(DW), .DEPTH_LOG2(DL2)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] exp_q [$];
    logic          m_ovr;
    logic          m_irq;
    int            compared;
    int            mismatched;

    // Model update from the currently driven inputs, then advance one edge.
    task automatic tick();
        logic pop_m, push_m, drop_m;
        pop_m  = bus.rd_en_i && (exp_q.size() != 0);
        push_m = bus.rx_valid_i && bus.en_i;
        if (!rstn) begin
            exp_q.delete();
            m_ovr = 1'b0;
        end else if (bus.clr_i) begin
            exp_q.delete();
            if (bus.ovr_clr_i) m_ovr = 1'b0;
        end else begin
            drop_m = push_m && (exp_q.size() == DEPTH) && !pop_m;
            if (pop_m) void'(exp_q.pop_front());
            if (push_m && !drop_m) exp_q.push_back(bus.rx_data_i);
            if (drop_m) m_ovr = 1'b1;
            else if (bus.ovr_clr_i) m_ovr = 1'b0;
        end
        m_irq = rstn && (bus.thresh_i != 0) && (exp_q.size() >= int'(bus.thresh_i));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx_valid_i = 1'b0;
        bus.rd_en_i    = 1'b0;
        bus.clr_i      = 1'b0;
        bus.ovr_clr_i  = 1'b0;
        bus.en_i       = 1'b1;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        bus.rx_data_i  = d;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        compared++; if (bus.empty_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty: got %0b expected 1", bus.empty_o); end
        compared++; if (bus.full_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.full_o); end
        compared++; if (bus.level_o !== LW'(0)) begin mismatched++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.level_o); end
        compared++; if (bus.overrun_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %0b expected 0", bus.overrun_o); end
        compared++; if (bus.irq_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_irq: got %0b expected 0", bus.irq_o); end
    endtask

    task automatic test_single();
        push_one(8'hA5);
        compared++; if (bus.empty_o !== 1'b0) begin mismatched++; $display("[TB] FAIL single_empty: got %0b expected 0", bus.empty_o); end
        compared++; if (bus.level_o !== LW'(1)) begin mismatched++; $display("[TB] FAIL single_level: got %0d expected 1", bus.level_o); end
        compared++; if (bus.rd_data_o !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_data: got %0h expected a5", bus.rd_data_o); end
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        compared++; if (bus.empty_o !== 1'b1) begin mismatched++; $display("[TB] FAIL single_pop_empty: got %0b expected 1", bus.empty_o); end
        compared++; if (bus.level_o !== LW'(0)) begin mismatched++; $display("[TB] FAIL single_pop_level: got %0d expected 0", bus.level_o); end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) begin
            compared++;
            if (bus.rd_data_o !== exp_q[0]) begin
                mismatched++;
                $display("[TB] FAIL %s_data[%0d]: got %0h expected %0h", name, i, bus.rd_data_o, exp_q[0]);
            end
            bus.rd_en_i = 1'b1;
            tick();
            bus.rd_en_i = 1'b0;
        end
        compared++; if (bus.empty_o !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_empty: got %0b expected 1", name, bus.empty_o); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) push_one(DW'(i));
        compared++; if (bus.full_o !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_full: got %0b expected 1", bus.full_o); end
        compared++; if (bus.level_o !== LW'(DEPTH)) begin mismatched++; $display("[TB] FAIL fill_level: got %0d expected %0d", bus.level_o, DEPTH); end
        push_one(8'hFF);
        compared++; if (bus.overrun_o !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_overrun: got %0b expected 1", bus.overrun_o); end
        compared++; if (bus.level_o !== LW'(DEPTH)) begin mismatched++; $display("[TB] FAIL fill_drop_level: got %0d expected %0d", bus.level_o, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            compared++;
            if (bus.rd_data_o !== DW'(i)) begin
                mismatched++;
                $display("[TB] FAIL fill_order[%0d]: got %0h expected %0h", i, bus.rd_data_o, DW'(i));
            end
            bus.rd_en_i = 1'b1;
            tick();
            bus.rd_en_i = 1'b0;
        end
        compared++; if (bus.empty_o !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_drained: got %0b expected 1", bus.empty_o); end
        bus.ovr_clr_i = 1'b1;
        tick();
        bus.ovr_clr_i = 1'b0;
        compared++; if (bus.overrun_o !== m_ovr) begin mismatched++; $display("[TB] FAIL fill_ovr_clr: got %0b expected %0b", bus.overrun_o, m_ovr); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) push_one(DW'(8'h20 + i));
        bus.rx_data_i  = 8'h55;
        bus.rx_valid_i = 1'b1;
        bus.rd_en_i    = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
        bus.rd_en_i    = 1'b0;
        compared++; if (bus.level_o !== LW'(DEPTH)) begin mismatched++; $display("[TB] FAIL fpp_level: got %0d expected %0d", bus.level_o, DEPTH); end
        compared++; if (bus.overrun_o !== 1'b0) begin mismatched++; $display("[TB] FAIL fpp_overrun: got %0b expected 0", bus.overrun_o); end
        compared++; if (bus.rd_data_o !== 8'h21) begin mismatched++; $display("[TB] FAIL fpp_head: got %0h expected 21", bus.rd_data_o); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            bus.rd_en_i = 1'b1;
            tick();
        end
        bus.rd_en_i = 1'b0;
        compared++; if (bus.rd_data_o !== 8'h55) begin mismatched++; $display("[TB] FAIL fpp_16th: got %0h expected 55", bus.rd_data_o); end
        drain("fpp");
    endtask

    task automatic test_wrap();
        int ops;
        logic [DW-1:0] next_val;
        ops = 0;
        next_val = 8'h80;
        for (int cyc = 0; cyc < 400 && ops < 40; cyc++) begin
            bus.rx_valid_i = 1'b0;
            bus.rd_en_i    = 1'b0;
            if ($urandom_range(0, 2) != 0) begin
                if (exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                    bus.rx_data_i  = next_val;
                    bus.rx_valid_i = 1'b1;
                    next_val       = next_val + 8'd7;
                end
                if (exp_q.size() != 0 && $urandom_range(0, 1) != 0) begin
                    compared++;
                    if (bus.rd_data_o !== exp_q[0]) begin
                        mismatched++;
                        $display("[TB] FAIL wrap_data: got %0h expected %0h", bus.rd_data_o, exp_q[0]);
                    end
                    bus.rd_en_i = 1'b1;
                end
                if (bus.rx_valid_i || bus.rd_en_i) ops++;
            end
            tick();
            compared++;
            if (bus.level_o !== LW'(exp_q.size())) begin
                mismatched++;
                $display("[TB] FAIL wrap_level: got %0d expected %0d", bus.level_o, exp_q.size());
            end
        end
        idle_inputs();
        compared++; if (ops < 40) begin mismatched++; $display("[TB] FAIL wrap_ops: got %0d expected 40", ops); end
        drain("wrap");
    endtask

    task automatic test_irq();
        bus.thresh_i = LW'(4);
        tick();
        for (int i = 0; i < 3; i++) push_one(DW'(i));
        compared++; if (bus.irq_o !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_below: got %0b expected 0", bus.irq_o); end
        push_one(8'h03);
        compared++; if (bus.irq_o !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_at: got %0b expected 1", bus.irq_o); end
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        compared++; if (bus.irq_o !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_pop: got %0b expected 0", bus.irq_o); end
        drain("irq");
        bus.thresh_i = LW'(0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            push_one(DW'(i));
            compared++;
            if (bus.irq_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL irq_zero[%0d]: got %0b expected 0", i, bus.irq_o);
            end
        end
        drain("irq0");
    endtask

    task automatic test_controls();
        for (int i = 0; i < DEPTH; i++) push_one(DW'(8'h40 + i));
        push_one(8'hEE);
        for (int i = 0; i < DEPTH - 5; i++) begin
            bus.rd_en_i = 1'b1;
            tick();
        end
        bus.rd_en_i = 1'b0;
        compared++; if (bus.level_o !== LW'(5)) begin mismatched++; $display("[TB] FAIL ctl_level5: got %0d expected 5", bus.level_o); end
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        compared++; if (bus.level_o !== LW'(0)) begin mismatched++; $display("[TB] FAIL ctl_clr_level: got %0d expected 0", bus.level_o); end
        compared++; if (bus.empty_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ctl_clr_empty: got %0b expected 1", bus.empty_o); end
        compared++; if (bus.overrun_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ctl_clr_ovr: got %0b expected 1", bus.overrun_o); end
        bus.ovr_clr_i = 1'b1;
        tick();
        bus.ovr_clr_i = 1'b0;
        compared++; if (bus.overrun_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ctl_ovr_clr: got %0b expected 0", bus.overrun_o); end

        for (int i = 0; i < DEPTH; i++) push_one(DW'(8'h60 + i));
        bus.ovr_clr_i = 1'b1;
        push_one(8'hDD);
        bus.ovr_clr_i = 1'b0;
        compared++; if (bus.overrun_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ctl_drop_vs_clr: got %0b expected 1", bus.overrun_o); end
        compared++; if (bus.overrun_o !== m_ovr) begin mismatched++; $display("[TB] FAIL ctl_ovr_model: got %0b expected %0b", bus.overrun_o, m_ovr); end
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;

        push_one(8'h11);
        push_one(8'h22);
        bus.en_i = 1'b0;
        for (int i = 0; i < 3; i++) push_one(DW'(8'h90 + i));
        compared++; if (bus.level_o !== LW'(2)) begin mismatched++; $display("[TB] FAIL ctl_en_level: got %0d expected 2", bus.level_o); end
        compared++; if (bus.rd_data_o !== 8'h11) begin mismatched++; $display("[TB] FAIL ctl_en_head: got %0h expected 11", bus.rd_data_o); end
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        bus.en_i = 1'b1;
        compared++; if (bus.rd_data_o !== 8'h22) begin mismatched++; $display("[TB] FAIL ctl_en_pop: got %0h expected 22", bus.rd_data_o); end

        bus.thresh_i = LW'(3);
        for (int i = 0; i < 6; i++) push_one(DW'(8'hB0 + i));
        compared++; if (bus.level_o !== LW'(7)) begin mismatched++; $display("[TB] FAIL ctl_level7: got %0d expected 7", bus.level_o); end
        compared++; if (bus.irq_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ctl_irq7: got %0b expected 1", bus.irq_o); end
        rstn = 1'b0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'hCC;
        bus.clr_i      = 1'b1;
        tick();
        idle_inputs();
        rstn = 1'b1;
        compared++; if (bus.level_o !== LW'(0)) begin mismatched++; $display("[TB] FAIL rst7_level: got %0d expected 0", bus.level_o); end
        compared++; if (bus.empty_o !== 1'b1) begin mismatched++; $display("[TB] FAIL rst7_empty: got %0b expected 1", bus.empty_o); end
        compared++; if (bus.full_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rst7_full: got %0b expected 0", bus.full_o); end
        compared++; if (bus.irq_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rst7_irq: got %0b expected 0", bus.irq_o); end
        compared++; if (bus.overrun_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rst7_ovr: got %0b expected 0", bus.overrun_o); end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        m_ovr        = 1'b0;
        m_irq        = 1'b0;
        rstn         = 1'b0;
        bus.rx_data_i = '0;
        bus.thresh_i  = '0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill_overrun();
        test_full_push_pop();
        test_wrap();
        test_irq();
        test_controls();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
